// File: rtl/fetch_controller_if.sv
// Bundles the ROM request/response channel and the decode-side output
// channel of the fetch controller. The controller is the master of both.
//
// Handshake rule for every valid/ready pair here: a transfer happens in a
// cycle where valid && ready are both 1 at the rising clock edge. A
// request's valid may be withdrawn before it is accepted; the response
// channel has no ready and is always taken.
interface fetch_controller_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_pc;
    logic [ADDR_W-1:0] out_next_pc;
    logic [31:0]       out_instr;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output out_valid, out_pc, out_next_pc, out_instr,
        input  out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  out_valid, out_pc, out_next_pc, out_instr,
        output out_ready
    );
endinterface

// File: rtl/fetch_controller.sv
// Fetch controller: owns the PC, keeps at most one ROM request in flight,
// buffers up to two returned instructions for decode and handles
// redirects from execute, dropping responses that became stale.
// dbg_state / dbg_occ expose the FSM state and buffer occupancy.
module fetch_controller #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              fetch_enable,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    fetch_controller_if.master bus,
    output logic [1:0]        dbg_state,
    output logic [1:0]        dbg_occ
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic              outstanding_q, outstanding_d;
    logic [1:0]        occ_q, occ_d;
    logic [ADDR_W-1:0] buf_pc_q [2];
    logic [ADDR_W-1:0] buf_pc_d [2];
    logic [31:0]       buf_instr_q [2];
    logic [31:0]       buf_instr_d [2];

    logic       pop;
    logic       rsp_take;
    logic       push;
    logic       req_valid;
    logic       req_fire;
    logic       issue_state;
    logic [2:0] reserve;
    logic [1:0] tail;
    logic       unused_target_lsbs;

    // Target bits [1:0] are forced to zero, so they are deliberately unused.
    assign unused_target_lsbs = ^redirect_target[1:0];

    // Issue decision: a request only goes out if a buffer slot is reserved for it.
    always_comb begin
        pop      = (occ_q != 2'd0) && bus.out_ready;
        // A response with nothing outstanding (e.g. one that straddled a
        // reset) belongs to no request and is ignored.
        rsp_take = bus.imem_rsp_valid && outstanding_q;
        reserve  = {1'b0, occ_q} + {2'b00, outstanding_q} - {2'b00, pop};
        // The stale response landing in DISCARD frees the request slot, so the
        // next request to the redirect target can leave in that same cycle.
        issue_state = (state_q == ST_RUN) || ((state_q == ST_DISCARD) && rsp_take);
        req_valid = issue_state && fetch_enable && !redirect_valid &&
                    (!outstanding_q || rsp_take) && (reserve < 3'd2);
        req_fire  = req_valid && bus.imem_req_ready;
    end

    // Next-state for FSM, PC, outstanding flag and the 2-entry buffer.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pend_pc_d     = pend_pc_q;
        outstanding_d = outstanding_q;
        occ_d         = occ_q;
        buf_pc_d      = buf_pc_q;
        buf_instr_d   = buf_instr_q;
        push          = 1'b0;
        tail          = occ_q - {1'b0, pop};

        case (state_q)
            ST_IDLE:    state_d = ST_RUN;
            ST_RUN:     if (redirect_valid && outstanding_q && !rsp_take) state_d = ST_DISCARD;
            ST_DISCARD: if (rsp_take) state_d = ST_RUN;
            default:    state_d = ST_IDLE;
        endcase

        if (rsp_take) outstanding_d = 1'b0;
        if (req_fire) begin
            outstanding_d = 1'b1;
            pc_d          = pc_q + PC_STEP;
            pend_pc_d     = pc_q;
        end

        push = rsp_take && (state_q == ST_RUN) && !redirect_valid;

        if (redirect_valid) begin
            // Flush: everything buffered is younger than the redirecting branch.
            pc_d  = {redirect_target[ADDR_W-1:2], 2'b00};
            occ_d = 2'd0;
        end else begin
            if (pop) begin
                buf_pc_d[0]    = buf_pc_q[1];
                buf_instr_d[0] = buf_instr_q[1];
            end
            if (push) begin
                if (tail == 2'd0) begin
                    buf_pc_d[0]    = pend_pc_q;
                    buf_instr_d[0] = bus.imem_rsp_data;
                end else begin
                    buf_pc_d[1]    = pend_pc_q;
                    buf_instr_d[1] = bus.imem_rsp_data;
                end
            end
            occ_d = occ_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            pend_pc_q     <= '0;
            outstanding_q <= 1'b0;
            occ_q         <= 2'd0;
            buf_pc_q      <= '{default: '0};
            buf_instr_q   <= '{default: '0};
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pend_pc_q     <= pend_pc_d;
            outstanding_q <= outstanding_d;
            occ_q         <= occ_d;
            buf_pc_q      <= buf_pc_d;
            buf_instr_q   <= buf_instr_d;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.out_valid      = (occ_q != 2'd0);
    assign bus.out_pc         = buf_pc_q[0];
    assign bus.out_next_pc    = buf_pc_q[0] + PC_STEP;
    assign bus.out_instr      = buf_instr_q[0];
    assign dbg_state          = state_q;
    assign dbg_occ            = occ_q;
endmodule
